// File: rtl/div_fn_unit.sv
// Iterative 32-bit integer divider (DIV/DIVU/REM/REMU) with a CDB result port.
// One restoring step per cycle; divide-by-zero and signed overflow finish immediately.
module div_fn_unit #(
    parameter int PR_BITS  = 5,
    parameter int ROB_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [2:0]          funct3,
    input  logic [31:0]         rs1_v,
    input  logic [31:0]         rs2_v,
    input  logic [PR_BITS-1:0]  pd_in,
    input  logic [ROB_BITS-1:0] rob_in,
    output logic                cdb_valid,
    input  logic                cdb_grant,
    output logic [PR_BITS-1:0]  cdb_pd,
    output logic [ROB_BITS-1:0] cdb_rob,
    output logic [31:0]         cdb_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_r;
    logic [4:0]  cnt_r;
    logic [31:0] quo_r;
    logic [31:0] dvs_r;
    logic [31:0] rem_r;
    logic        q_neg_r;
    logic        r_neg_r;
    logic        is_rem_r;

    logic        accept_s;
    logic        signed_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic        div0_s;
    logic        ovf_s;
    logic [31:0] special_data_s;
    logic [32:0] shift_s;
    logic [32:0] diff_s;
    logic [31:0] rem_nxt_s;
    logic [31:0] quo_nxt_s;
    logic [31:0] fin_s;
    logic        unused_s;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    // Issue handshake, operand decode and special-case detection
    always_comb begin
        issue_ready = (state_r == IDLE) & ~flush;
        accept_s    = issue_valid & issue_ready;
        signed_s    = ~funct3[0];
        unused_s    = funct3[2];
        a_neg_s     = signed_s & rs1_v[31];
        b_neg_s     = signed_s & rs2_v[31];
        a_mag_s     = neg_if(rs1_v, a_neg_s);
        b_mag_s     = neg_if(rs2_v, b_neg_s);
        div0_s      = (rs2_v == 32'd0);
        ovf_s       = signed_s & (rs1_v == 32'h8000_0000) & (rs2_v == 32'hFFFF_FFFF);
        if (div0_s) begin
            special_data_s = funct3[1] ? rs1_v : 32'hFFFF_FFFF;
        end else if (ovf_s) begin
            special_data_s = funct3[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            special_data_s = 32'd0;
        end
    end

    // One restoring step; the 33-bit subtract exposes the borrow
    always_comb begin
        shift_s = {rem_r, quo_r[31]};
        diff_s  = shift_s - {1'b0, dvs_r};
        if (!diff_s[32]) begin
            rem_nxt_s = diff_s[31:0];
            quo_nxt_s = {quo_r[30:0], 1'b1};
        end else begin
            rem_nxt_s = shift_s[31:0];
            quo_nxt_s = {quo_r[30:0], 1'b0};
        end
        fin_s = is_rem_r ? neg_if(rem_nxt_s, r_neg_r) : neg_if(quo_nxt_s, q_neg_r);
    end

    // Control FSM, datapath registers and registered CDB outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 5'd0;
            quo_r     <= 32'd0;
            dvs_r     <= 32'd0;
            rem_r     <= 32'd0;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            is_rem_r  <= 1'b0;
            cdb_valid <= 1'b0;
            cdb_pd    <= '0;
            cdb_rob   <= '0;
            cdb_data  <= 32'd0;
        end else if (flush) begin
            state_r   <= IDLE;
            cnt_r     <= 5'd0;
            cdb_valid <= 1'b0;
            cdb_data  <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cdb_pd   <= pd_in;
                        cdb_rob  <= rob_in;
                        is_rem_r <= funct3[1];
                        q_neg_r  <= a_neg_s ^ b_neg_s;
                        r_neg_r  <= a_neg_s;
                        quo_r    <= a_mag_s;
                        dvs_r    <= b_mag_s;
                        rem_r    <= 32'd0;
                        cnt_r    <= 5'd0;
                        if (div0_s || ovf_s) begin
                            state_r   <= DONE;
                            cdb_valid <= 1'b1;
                            cdb_data  <= special_data_s;
                        end else begin
                            state_r <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    rem_r <= rem_nxt_s;
                    quo_r <= quo_nxt_s;
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_r   <= DONE;
                        cdb_valid <= 1'b1;
                        cdb_data  <= fin_s;
                    end else begin
                        state_r <= CALC;
                    end
                end
                DONE: begin
                    if (cdb_grant) begin
                        state_r   <= IDLE;
                        cdb_valid <= 1'b0;
                        cdb_data  <= 32'd0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= 5'd0;
                    cdb_valid <= 1'b0;
                    cdb_data  <= 32'd0;
                end
            endcase
        end
    end

endmodule
